// File: rtl/ula_issue_stage.sv
// Decode-to-execute stage register: ALU control decode, M/W operand forwarding, operand select.
// Latency 1 cycle D->E; no backpressure of its own, StallE holds and FlushE bubbles the stage.
module ula_issue_stage (
   input  logic       clk,
   input  logic       reset,
   input  logic       ValidD,
   input  logic       StallE,
   input  logic       FlushE,
   input  logic [1:0] ALUOp,
   input  logic [2:0] Funct3,
   input  logic       Funct7b5,
   input  logic       Funct7b0,
   input  logic       OpB5,
   input  logic       ALUSrcD,
   input  logic       RegWriteD,
   input  logic [7:0] RD1D,
   input  logic [7:0] RD2D,
   input  logic [7:0] ImmExtD,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] RdD,
   input  logic [4:0] RdM,
   input  logic       RegWriteM,
   input  logic [7:0] ULAResultM,
   input  logic [4:0] RdW,
   input  logic       RegWriteW,
   input  logic [7:0] ResultW,
   output logic [7:0] SrcA,
   output logic [7:0] SrcB,
   output logic [3:0] ULAControl,
   output logic [4:0] RdE,
   output logic       RegWriteE,
   output logic       ValidE,
   output logic [7:0] WriteDataE
);

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic [3:0] ula_ctrl;
      logic       alu_src;
      logic [7:0] rd1;
      logic [7:0] rd2;
      logic [7:0] imm;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } stage_t;

   stage_t     stage_d, stage_q;
   logic [3:0] ula_ctrl_dec;
   logic [7:0] fwd_a, fwd_b;

   always_comb begin
      ula_ctrl_dec = 4'b0000;
      case (ALUOp)
         2'b01: ula_ctrl_dec = (Funct3 == 3'b001) ? 4'b0111 : 4'b0001;
         2'b10: begin
            case (Funct3)
               3'b000: begin
                  // mul (M-extension) takes precedence over sub when both funct7 bits are set
                  if (OpB5 && Funct7b0)      ula_ctrl_dec = 4'b0110;
                  else if (OpB5 && Funct7b5) ula_ctrl_dec = 4'b0001;
                  else                       ula_ctrl_dec = 4'b0000;
               end
               3'b100:  ula_ctrl_dec = (OpB5 && Funct7b0) ? 4'b1000 : 4'b0100;
               3'b010:  ula_ctrl_dec = 4'b0101;
               3'b110:  ula_ctrl_dec = 4'b0011;
               3'b111:  ula_ctrl_dec = 4'b0010;
               default: ula_ctrl_dec = 4'b0000;
            endcase
         end
         default: ula_ctrl_dec = 4'b0000;
      endcase
   end

   always_comb begin
      stage_d = stage_q;
      if (FlushE) begin
         stage_d = '0;
      end else if (!StallE) begin
         stage_d.valid     = ValidD;
         stage_d.reg_write = ValidD & RegWriteD;
         stage_d.ula_ctrl  = ula_ctrl_dec;
         stage_d.alu_src   = ALUSrcD;
         stage_d.rd1       = RD1D;
         stage_d.rd2       = RD2D;
         stage_d.imm       = ImmExtD;
         stage_d.rs1       = Rs1D;
         stage_d.rs2       = Rs2D;
         stage_d.rd        = RdD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stage_q <= '0;
      else       stage_q <= stage_d;
   end

   // Memory stage is younger than write-back, so it wins; x0 is never forwarded.
   always_comb begin
      fwd_a = stage_q.rd1;
      if (RegWriteM && (RdM != 5'd0) && (RdM == stage_q.rs1))      fwd_a = ULAResultM;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == stage_q.rs1)) fwd_a = ResultW;

      fwd_b = stage_q.rd2;
      if (RegWriteM && (RdM != 5'd0) && (RdM == stage_q.rs2))      fwd_b = ULAResultM;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == stage_q.rs2)) fwd_b = ResultW;
   end

   assign SrcA       = fwd_a;
   assign SrcB       = stage_q.alu_src ? stage_q.imm : fwd_b;
   assign WriteDataE = fwd_b;
   assign ULAControl = stage_q.ula_ctrl;
   assign RdE        = stage_q.rd;
   assign RegWriteE  = stage_q.reg_write;
   assign ValidE     = stage_q.valid;

endmodule

// File: doc/ula_issue_stage.md
ULA_ISSUE_STAGE -- requirements
Module: ula_issue_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; port list: clk, reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all stage registers.
REQ-004 ValidD  input  1  decode slot holds a real instruction.
REQ-005 StallE  input  1  hold stage contents this cycle.
REQ-006 FlushE  input  1  replace stage contents with a bubble this cycle.
REQ-007 ALUOp  input  2  00 = load/store, 01 = branch, 10 = R/I arithmetic, 11 = reserved.
REQ-008 Funct3  input  3; Funct7b5  input  1; Funct7b0  input  1; OpB5  input  1 (1 = R-type).
REQ-009 ALUSrcD  input  1  1 = SrcB takes ImmExtD; RegWriteD  input  1.
REQ-010 RD1D, RD2D, ImmExtD  input  8 each  register-file and immediate operands.
REQ-011 Rs1D, Rs2D, RdD  input  5 each  register indices.
REQ-012 RdM  input  5; RegWriteM  input  1; ULAResultM  input  8  (memory-stage result).
REQ-013 RdW  input  5; RegWriteW  input  1; ResultW  input  8  (write-back result).
REQ-014 SrcA, SrcB  output  8  ALU operands; ULAControl  output  4  ALU operation code.
REQ-015 RdE  output  5; RegWriteE  output  1; ValidE  output  1; WriteDataE  output  8 (forwarded rs2 for stores).

Function
REQ-016 The stage register SHALL capture, on each rising clk edge, ULAControl, ALUSrc, RD1, RD2, ImmExt, Rs1, Rs2, Rd, RegWrite, and Valid from the D-side inputs.
REQ-017 FlushE=1 SHALL load a bubble (every field 0) on the next edge, taking priority over StallE.
REQ-018 StallE=1 with FlushE=0 SHALL hold all stage registers unchanged.
REQ-019 ValidD=0 SHALL load RegWrite=0 and Valid=0; all other fields are captured normally.
REQ-020 ULAControl SHALL be decoded combinationally from D-side fields and registered (1-cycle latency), as follows:
- ALUOp 00: 0000 (add).
- ALUOp 01: Funct3 001 gives 0111 (bne); any other Funct3 gives 0001 (sub).
- ALUOp 10: Funct3 000 gives 0110 (mul) if OpB5 and Funct7b0; 0001 (sub) if OpB5 and Funct7b5; else 0000.
- ALUOp 10: Funct3 100 gives 1000 (div) if OpB5 and Funct7b0; else 0100 (xor).
- ALUOp 10: Funct3 010 gives 0101; 110 gives 0011; 111 gives 0010; any other Funct3 gives 0000.
- ALUOp 11: 0000.
REQ-021 Forward-A SHALL be evaluated combinationally from the registered Rs1E:
- select ULAResultM if RegWriteM=1, RdM≠0 and RdM=Rs1E;
- else select ResultW if RegWriteW=1, RdW≠0 and RdW=Rs1E;
- else select RD1E.
REQ-022 Forward-B SHALL apply the same rule to Rs2E and RD2E; its result drives WriteDataE.
REQ-023 SrcA SHALL equal forward-A; SrcB SHALL equal ImmExtE when ALUSrcE=1, else forward-B.
REQ-024 Register index 0 SHALL never be forwarded; when M and W both match, M SHALL win.
REQ-025 RdE, RegWriteE, ValidE, and ULAControl SHALL be driven directly from the stage registers.
REQ-026 All arithmetic SHALL be 8-bit with no width extension.

Reset
REQ-027 While reset=1, all stage registers SHALL be 0, independent of clk.
REQ-028 After reset, SrcA=SrcB=0, ULAControl=0000, RdE=0, RegWriteE=0, ValidE=0, WriteDataE=0.
REQ-029 When reset asserts mid-stall or mid-flush, reset SHALL win; the first edge after deassertion SHALL capture D-side inputs normally.

Verification
REQ-030 Decode: ALUOp=10, Funct3=000, OpB5=1, Funct7b5=1, RD1D=9, RD2D=4 -> next cycle ULAControl=0001, SrcA=9, SrcB=4, ValidE=1.
REQ-031 Forward priority: Rs1E=3; RdM=3, RegWriteM=1, ULAResultM=0x55; RdW=3, RegWriteW=1, ResultW=0x22 -> SrcA=0x55; clear RegWriteM -> SrcA=0x22.
REQ-032 x0 guard: Rs2E=0, RdM=0, RegWriteM=1, ULAResultM=0xFF, ALUSrcE=0, RD2E=0x07 -> SrcB=0x07, WriteDataE=0x07.
REQ-033 Stall/flush: StallE=1 for 2 cycles with changing D inputs -> outputs unchanged; FlushE=1 together with StallE=1 -> next cycle ValidE=0, RegWriteE=0, ULAControl=0000.
REQ-034 Immediate/bne: ALUOp=01, Funct3=001 -> ULAControl=0111; ALUSrcD=1, ImmExtD=0x10 -> SrcB=0x10.
REQ-035 Async reset: assert reset between clk edges with ValidE=1 -> ValidE=0 and ULAControl=0000 before the next edge.
